// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: CPU (fixed priority) plus two device DMA ports.
// Define RAM_ARB_STARVE_GUARD_EN to bound how long a device can wait behind the CPU.
module ram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CORE_CLK,
    input  logic        RESET_N,
    input  logic        CPU_req,
    input  logic [15:0] CPU_addr,
    input  logic [15:0] CPU_data,
    input  logic        CPU_wr,
    output logic        CPU_wait,
    output logic [15:0] CPU_q,
    input  logic        DEV0_req,
    input  logic [15:0] DEV0_addr,
    input  logic [15:0] DEV0_data,
    input  logic        DEV0_wr,
    output logic        DEV0_gnt,
    output logic        DEV0_rvalid,
    output logic [15:0] DEV0_q,
    input  logic        DEV1_req,
    input  logic [15:0] DEV1_addr,
    input  logic [15:0] DEV1_data,
    input  logic        DEV1_wr,
    output logic        DEV1_gnt,
    output logic        DEV1_rvalid,
    output logic [15:0] DEV1_q,
    output logic [15:0] RAM_addr,
    output logic [15:0] RAM_data,
    output logic        RAM_wr,
    input  logic [15:0] RAM_q,
    output logic [1:0]  last_owner
);

    typedef enum logic [1:0] {
        OWNER_IDLE = 2'd0,
        OWNER_CPU  = 2'd1,
        OWNER_DEV0 = 2'd2,
        OWNER_DEV1 = 2'd3
    } owner_t;

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("ram_arbiter: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    logic [1:0]  dev_req;
    logic [1:0]  dev_wr;
    logic [15:0] dev_addr [2];
    logic [15:0] dev_data [2];

    assign dev_req     = {DEV1_req, DEV0_req};
    assign dev_wr      = {DEV1_wr, DEV0_wr};
    assign dev_addr[0] = DEV0_addr;
    assign dev_addr[1] = DEV1_addr;
    assign dev_data[0] = DEV0_data;
    assign dev_data[1] = DEV1_data;

    owner_t     owner_reg, owner_next;
    logic       rr_ptr_reg, rr_ptr_next;
    logic [1:0] rvalid_reg;
    logic       cpu_gnt;
    logic [1:0] dev_gnt;
    logic       any_dev;
    logic       cpu_allowed;
    logic       dev_sel;

    assign any_dev = |dev_req;

`ifdef RAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
    logic [3:0] cpu_run_reg, cpu_run_next;

    // CPU keeps priority only while its run of contended grants is below the limit
    assign cpu_allowed = ~any_dev | (cpu_run_reg < LIMIT);
    assign CPU_wait    = CPU_req & ~cpu_gnt;

    always_comb begin
        cpu_run_next = 4'd0;
        if (cpu_gnt && any_dev) begin
            cpu_run_next = (cpu_run_reg == 4'hF) ? 4'hF : cpu_run_reg + 4'd1;
        end
    end

    always_ff @(posedge CORE_CLK) begin
        if (!RESET_N) begin
            cpu_run_reg <= 4'd0;
        end else begin
            cpu_run_reg <= cpu_run_next;
        end
    end
`else
    assign cpu_allowed = 1'b1;
    assign CPU_wait    = 1'b0;
`endif

    always_comb begin
        cpu_gnt     = 1'b0;
        dev_gnt     = 2'b00;
        dev_sel     = 1'b0;
        owner_next  = OWNER_IDLE;
        rr_ptr_next = rr_ptr_reg;
        if (CPU_req && cpu_allowed) begin
            cpu_gnt    = 1'b1;
            owner_next = OWNER_CPU;
        end else if (any_dev) begin
            // rr_ptr only matters when both devices contend
            dev_sel          = (&dev_req) ? rr_ptr_reg : dev_req[1];
            dev_gnt[dev_sel] = 1'b1;
            owner_next       = dev_sel ? OWNER_DEV1 : OWNER_DEV0;
            rr_ptr_next      = ~dev_sel;
        end
    end

    always_comb begin
        RAM_addr = 16'd0;
        RAM_data = 16'd0;
        RAM_wr   = 1'b0;
        if (cpu_gnt) begin
            RAM_addr = CPU_addr;
            RAM_data = CPU_data;
            RAM_wr   = CPU_wr;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (dev_gnt[i]) begin
                    RAM_addr = dev_addr[i];
                    RAM_data = dev_data[i];
                    RAM_wr   = dev_wr[i];
                end
            end
        end
    end

    always_ff @(posedge CORE_CLK) begin
        if (!RESET_N) begin
            owner_reg  <= OWNER_IDLE;
            rr_ptr_reg <= 1'b0;
            rvalid_reg <= 2'b00;
        end else begin
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            rvalid_reg <= dev_gnt & ~dev_wr;
        end
    end

    assign CPU_q       = RAM_q;
    assign DEV0_q      = RAM_q;
    assign DEV1_q      = RAM_q;
    assign DEV0_gnt    = dev_gnt[0];
    assign DEV1_gnt    = dev_gnt[1];
    assign DEV0_rvalid = rvalid_reg[0];
    assign DEV1_rvalid = rvalid_reg[1];
    assign last_owner  = owner_reg;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural 64Kx16 RAM.
// Expectations follow RAM_ARB_STARVE_GUARD_EN the same way the design does.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_wr, cpu_wait;
    logic [15:0] cpu_addr, cpu_data, cpu_q;
    logic        dev0_req, dev0_wr, dev0_gnt, dev0_rvalid;
    logic [15:0] dev0_addr, dev0_data, dev0_q;
    logic        dev1_req, dev1_wr, dev1_gnt, dev1_rvalid;
    logic [15:0] dev1_addr, dev1_data, dev1_q;
    logic [15:0] ram_addr, ram_data, ram_q;
    logic        ram_wr;
    logic [1:0]  last_owner;

    logic [15:0] mem [65536];

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wr) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    ram_arbiter #(.STARVE_LIMIT(4)) dut (
        .CORE_CLK(clk), .RESET_N(reset_n),
        .CPU_req(cpu_req), .CPU_addr(cpu_addr), .CPU_data(cpu_data), .CPU_wr(cpu_wr),
        .CPU_wait(cpu_wait), .CPU_q(cpu_q),
        .DEV0_req(dev0_req), .DEV0_addr(dev0_addr), .DEV0_data(dev0_data), .DEV0_wr(dev0_wr),
        .DEV0_gnt(dev0_gnt), .DEV0_rvalid(dev0_rvalid), .DEV0_q(dev0_q),
        .DEV1_req(dev1_req), .DEV1_addr(dev1_addr), .DEV1_data(dev1_data), .DEV1_wr(dev1_wr),
        .DEV1_gnt(dev1_gnt), .DEV1_rvalid(dev1_rvalid), .DEV1_q(dev1_q),
        .RAM_addr(ram_addr), .RAM_data(ram_data), .RAM_wr(ram_wr), .RAM_q(ram_q),
        .last_owner(last_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_count++;
        if (got === exp) pass_count++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // One CPU access: checks the grant mid-cycle, returns after the edge.
    task automatic cpu_access(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_data = data;
        mid();
        check("cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check("cpu_ram_addr", {16'd0, ram_addr}, {16'd0, addr});
        check("cpu_ram_wr", {31'd0, ram_wr}, {31'd0, wr});
        $display("cpu %s addr=%04h data=%04h", wr ? "wr" : "rd", addr, data);
        step();
        cpu_req = 1'b0; cpu_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic e0, e1, prev0, prev1, exp_d;
        reset_n = 1'b0;
        cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_data = 0;
        dev0_req = 0; dev0_wr = 0; dev0_addr = 0; dev0_data = 0;
        dev1_req = 0; dev1_wr = 0; dev1_addr = 0; dev1_data = 0;

        // Reset and idle
        step(); step();
        reset_n = 1'b1;
        mid();
        check("idle_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("idle_ram_addr", {16'd0, ram_addr}, 32'd0);
        check("idle_gnts", {30'd0, dev1_gnt, dev0_gnt}, 32'd0);
        check("idle_cpu_wait", {31'd0, cpu_wait}, 32'd0);
        check("idle_rvalid", {30'd0, dev1_rvalid, dev0_rvalid}, 32'd0);
        check("idle_owner", {30'd0, last_owner}, 32'd0);
        $display("idle after reset");
        step();

        // CPU write then read, plus preload for device reads
        cpu_access(1'b1, 16'h1234, 16'hBEEF);
        check("owner_cpu", {30'd0, last_owner}, 32'd1);
        cpu_access(1'b0, 16'h1234, 16'h0000);
        check("cpu_q_beef", {16'd0, cpu_q}, 32'h0000BEEF);
        cpu_access(1'b1, 16'h0010, 16'h1111);
        cpu_access(1'b1, 16'h0020, 16'h2222);

        // Round-robin: both devices reading continuously
        dev0_req = 1; dev0_addr = 16'h0010;
        dev1_req = 1; dev1_addr = 16'h0020;
        prev0 = 0; prev1 = 0;
        for (int c = 0; c < 4; c++) begin
            e0 = (c % 2 == 0);
            e1 = ~e0;
            mid();
            check("rr_dev0_gnt", {31'd0, dev0_gnt}, {31'd0, e0});
            check("rr_dev1_gnt", {31'd0, dev1_gnt}, {31'd0, e1});
            $display("rr cycle %0d dev0_gnt=%0b dev1_gnt=%0b", c, dev0_gnt, dev1_gnt);
            step();
            check("rr_dev0_rvalid", {31'd0, dev0_rvalid}, {31'd0, e0});
            check("rr_dev1_rvalid", {31'd0, dev1_rvalid}, {31'd0, e1});
            check("rr_q", {16'd0, dev0_q}, e0 ? 32'h1111 : 32'h2222);
            prev0 = e0; prev1 = e1;
        end
        dev0_req = 0; dev1_req = 0;
        mid();
        check("rr_idle_addr", {16'd0, ram_addr}, 32'd0);
        step();
        check("rr_rvalid_end", {30'd0, dev1_rvalid, dev0_rvalid}, 32'd0);
        check("owner_idle", {30'd0, last_owner}, 32'd0);

        // DEV1 write, no rvalid, then CPU sees the new data
        dev1_req = 1; dev1_wr = 1; dev1_addr = 16'h0030; dev1_data = 16'hCAFE;
        mid();
        check("dev1_wr_gnt", {31'd0, dev1_gnt}, 32'd1);
        check("dev1_wr_ram_wr", {31'd0, ram_wr}, 32'd1);
        $display("dev1 wr addr=0030 data=cafe");
        step();
        dev1_req = 0; dev1_wr = 0;
        check("dev1_wr_no_rvalid", {31'd0, dev1_rvalid}, 32'd0);
        check("owner_dev1", {30'd0, last_owner}, 32'd3);
        cpu_access(1'b0, 16'h0030, 16'h0000);
        check("cpu_q_cafe", {16'd0, cpu_q}, 32'h0000CAFE);

        // Starvation guard: CPU every cycle, DEV0 held requesting
        cpu_req = 1; cpu_wr = 0; cpu_addr = 16'h1234;
        dev0_req = 1; dev0_wr = 0; dev0_addr = 16'h0010;
        for (int c = 0; c < 10; c++) begin
`ifdef RAM_ARB_STARVE_GUARD_EN
            exp_d = (c % 5 == 4);
`else
            exp_d = 1'b0;
`endif
            mid();
            check("starve_dev0_gnt", {31'd0, dev0_gnt}, {31'd0, exp_d});
            check("starve_cpu_wait", {31'd0, cpu_wait}, {31'd0, exp_d});
            $display("starve cycle %0d dev0_gnt=%0b cpu_wait=%0b", c, dev0_gnt, cpu_wait);
            step();
        end
        cpu_req = 0;
        mid();
        check("starve_release_gnt", {31'd0, dev0_gnt}, 32'd1);
        step();
        dev0_req = 0;
        check("owner_dev0", {30'd0, last_owner}, 32'd2);

        // Reset while a DEV1 read is in flight
        dev1_req = 1; dev1_wr = 0; dev1_addr = 16'h0010;
        mid();
        check("rst_dev1_gnt", {31'd0, dev1_gnt}, 32'd1);
        $display("dev1 rd addr=0010 then reset");
        reset_n = 0;
        dev1_req = 0;
        step();
        check("rst_rvalid_suppressed", {31'd0, dev1_rvalid}, 32'd0);
        reset_n = 1;
        step();
        check("rst_rvalid_after", {31'd0, dev1_rvalid}, 32'd0);
        dev0_req = 1; dev1_req = 1;
        mid();
        check("rst_rr_dev0", {31'd0, dev0_gnt}, 32'd1);
        check("rst_rr_dev1", {31'd0, dev1_gnt}, 32'd0);
        step();
        dev0_req = 0; dev1_req = 0;
        check("rst_rr_rvalid", {31'd0, dev0_rvalid}, 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Single-port RAM arbiter that shares the 64K×16 main memory between the CPU core and two hardware-device DMA ports: display refresh on DEV0 and disk/DMA on DEV1. The CPU has fixed priority. A starvation guard forces a device slot after a bounded run of CPU accesses and stalls the CPU through `CPU_wait`. The block sits between the CPU/device masters and the RAM macro, which has a 1-cycle read latency and writes on the clock edge.

## Interface
Parameters:
- `STARVE_LIMIT`, default 4: maximum consecutive CPU grants while any device is requesting. Legal range 1..15.

Ports:
- `CORE_CLK` in 1: core clock. All logic is rising-edge.
- `RESET_N` in 1: reset, synchronous, active-low.
- `CPU_req` in 1: CPU access request, valid for this cycle only.
- `CPU_addr` in 16: CPU address.
- `CPU_data` in 16: CPU write data.
- `CPU_wr` in 1: CPU write enable. Qualified by `CPU_req`.
- `CPU_wait` out 1: CPU request not serviced this cycle. The CPU must hold its request.
- `CPU_q` out 16: read data. Equals `RAM_q`, valid the cycle after the CPU grant.
- `DEVn_req` in 1 (n = 0, 1): device request. Held until `DEVn_gnt`.
- `DEVn_addr` in 16, `DEVn_data` in 16, `DEVn_wr` in 1: device access fields.
- `DEVn_gnt` out 1: access performed at this edge. Combinational.
- `DEVn_rvalid` out 1: registered. `DEVn_q` holds read data this cycle.
- `DEVn_q` out 16: device read data.
- `RAM_addr` out 16, `RAM_data` out 16, `RAM_wr` out 1: RAM port.
- `RAM_q` in 16: RAM read data, 1-cycle latency.

## Operation
- Each cycle, exactly one requester owns the RAM port. An idle port drives `RAM_addr` 0, `RAM_data` 0 and `RAM_wr` 0.
- Registered state:
  - `last_owner` ∈ {IDLE, CPU, DEV0, DEV1}.
  - `cpu_run` counter, 4 bits, saturating.
  - `rr_ptr`, 1 bit, naming the next device favoured.
- Grant decision, combinational:
  - If `CPU_req` and no `DEVn_req`: grant CPU.
  - If `CPU_req` and any device is requesting and `cpu_run < STARVE_LIMIT`: grant CPU.
  - Otherwise, if any device is requesting: grant a device. When both request, `rr_ptr` selects; a single requester wins regardless of `rr_ptr`.
  - Otherwise: IDLE.
- `CPU_wait` = `CPU_req` & ~CPU granted.
- Update at the edge:
  - CPU granted while any device is requesting: `cpu_run` += 1, saturating at 15.
  - Device granted: `cpu_run` cleared, `rr_ptr` set to the other device.
  - No device requesting: `cpu_run` cleared.
- Read return: `DEVn_rvalid` is a 1-cycle pulse in the cycle after a granted read, never after a write. `DEVn_q` = `RAM_q`.
- State transitions:
  - IDLE→CPU on a CPU grant.
  - Any→DEVn on a device grant.
  - Any→IDLE when nothing is requesting.
  - `last_owner` is for debug/observability only.
- No address arithmetic is done, so there is no wrap-around.
- Same-address contention is resolved purely by grant order. A write followed by a read of the same address by another master returns the new data.

## Timing
- Reset values:
  - `rr_ptr` = 0 (DEV0 favoured).
  - `cpu_run` = 0.
  - `last_owner` = IDLE.
  - `DEVn_rvalid` = 0.
  - With no requests: `CPU_wait` 0, `DEVn_gnt` 0, `RAM_wr` 0.
- Reset while a read is in flight suppresses the pending `rvalid`.
- Grant-to-access latency is 0 cycles: the address is presented in the grant cycle.
- Read data arrives at grant + 1 cycle.
- Device handshake:
  - The device keeps `req` and its fields stable until it sees `gnt` high.
  - It may re-assert `req` in the cycle after `gnt` for back-to-back accesses.
- Worst-case device wait:
  - `STARVE_LIMIT` + 1 cycles with the guard compiled in and the other device idle.
  - 2·(`STARVE_LIMIT`+1) cycles with both devices contending.
- Worst-case CPU stall: 1 cycle per `STARVE_LIMIT` CPU accesses.

## Configuration
- `RAM_ARB_STARVE_GUARD_EN` defined: the starvation guard operates as described above.
- Undefined:
  - The CPU has absolute priority; `CPU_wait` is tied 0.
  - `cpu_run` is removed.
  - Devices are served only in cycles where `CPU_req` is low.

## Test plan
- Reset and idle:
  - Stimulus: `RESET_N` low for 2 cycles, then no requests.
  - Response: `RAM_wr` 0, all grants 0, `DEVn_rvalid` 0, `CPU_wait` 0.
- CPU write then read:
  - Stimulus: CPU writes 0xBEEF to 0x1234, then reads 0x1234.
  - Response: `CPU_wait` 0 throughout; `CPU_q` = 0xBEEF one cycle after the read.
- Round-robin between devices:
  - Stimulus: DEV0 and DEV1 both continuously reading, CPU idle.
  - Response: grants alternate DEV0, DEV1, DEV0…, starting with DEV0 after reset; each `rvalid` follows its grant by 1 cycle.
- Starvation guard (macro defined, `STARVE_LIMIT`=4):
  - Stimulus: CPU requesting every cycle, DEV0 held requesting.
  - Response: CPU granted 4 cycles; DEV0 `gnt` on cycle 5 with `CPU_wait`=1; the pattern repeats every 5 cycles.
- Starvation guard compiled out:
  - Stimulus: same as the previous scenario.
  - Response: `DEV0_gnt` stays 0 until `CPU_req` drops; `CPU_wait` is never 1.
- Reset mid-read:
  - Stimulus: DEV1 granted a read from 0x0010, `RESET_N` low on the next edge.
  - Response: `DEV1_rvalid` stays 0 and `rr_ptr` returns to DEV0.
